mix_columns_seq: RTL and testbench

- Iterative AES MixColumns stage. Sits directly downstream of shiftRows and consumes its 128-bit output state.
- Processes COLS_PER_CYCLE columns per clock, trading area for latency.
- Uses a valid/ready handshake on both sides.
- Provides a bypass for the final AES round, which has no MixColumns.

---
 rtl/mix_columns_seq_if.sv | 20 ++
 rtl/mix_columns_seq.sv | 98 +++++++++
 tb/tb_mix_columns_seq.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mix_columns_seq_if.sv
// Valid/ready bundle carrying AES states into and out of the iterative MixColumns stage.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_last_round, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_last_round, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: transforms COLS_PER_CYCLE columns per BUSY cycle in place,
// with a pass-through path for the final round.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  mix_columns_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [3:0][31:0] buf_q, buf_d;
  logic [2:0]       cnt_sum;
  logic [1:0]       col_idx [COLS_PER_CYCLE];
  logic [31:0]      col_mix [COLS_PER_CYCLE];

  // Column c lives in buf_q[3-c] (column 0 in the MSBs), hence the ~ on the 2-bit index.
  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
    assign col_idx[gi] = cnt_q + 2'(gi);
    assign col_mix[gi] = mix_column(buf_q[~col_idx[gi]]);
  end

  // Bit 2 of the sum marks the final column group; the low bits wrap to 0 on entry to DONE.
  assign cnt_sum       = {1'b0, cnt_q} + STEP;
  assign bus.in_ready  = (state_q == IDLE) & ~rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = buf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          buf_d   = bus.in_state;
          cnt_d   = '0;
          state_d = bus.in_last_round ? DONE : BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          buf_d[~col_idx[i]] = col_mix[i];
        end
        cnt_d = cnt_sum[1:0];
        if (cnt_sum[2]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and randomized checks of mix_columns_seq at COLS_PER_CYCLE = 1, 2 and 4
// against a generic GF(2^8) matrix-multiply model.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [127:0] in_state_s;
  logic         in_last_s;
  logic         in_valid_v    [3];
  logic         out_ready_v   [3];
  logic         obs_in_ready  [3];
  logic         obs_out_valid [3];
  logic [127:0] obs_out_state [3];

  mix_columns_seq_if ifs [3] ();

  // Index d drives the instance with COLS_PER_CYCLE = 1 << d.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mix_columns_seq #(.COLS_PER_CYCLE(1 << gi)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifs[gi].slave)
    );
    assign ifs[gi].in_valid      = in_valid_v[gi];
    assign ifs[gi].in_state      = in_state_s;
    assign ifs[gi].in_last_round = in_last_s;
    assign ifs[gi].out_ready     = out_ready_v[gi];
    assign obs_in_ready[gi]      = ifs[gi].in_ready;
    assign obs_out_valid[gi]     = ifs[gi].out_valid;
    assign obs_out_state[gi]     = ifs[gi].out_state;
  end

  int tests  = 0;
  int failed = 0;

  localparam logic [127:0] FIPS_IN  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
  localparam logic [127:0] V2_IN    = 128'hd4d4d4d52d26314cdb135345f20a225c;
  localparam logic [127:0] V2_OUT   = 128'hd5d5d7d64d7ebdf88e4da1bc9fdc589d;
  localparam logic [127:0] BYP_IN   = 128'h00112233445566778899aabbccddeeff;

  // Shift-and-add multiply reduced by the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) p = p ^ ({8'h00, a} << i);
    end
    for (int i = 15; i >= 8; i--) begin
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] st);
    int          coef [4];
    logic [7:0]  a    [4];
    logic [7:0]  b;
    logic [127:0] res;
    coef = '{2, 3, 1, 1};
    res  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = st[127 - 8 * (4 * c + r) -: 8];
      for (int r = 0; r < 4; r++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gmul(a[j], coef[(j - r + 4) % 4]);
        res[127 - 8 * (4 * c + r) -: 8] = b;
      end
    end
    return res;
  endfunction

  task automatic chk_state(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block through instance d; optionally stalls out_ready for 'hold' cycles in DONE.
  task automatic run_block(input int d, input logic [127:0] st, input logic last,
                           input logic [127:0] exp, input int hold, input string tag);
    int lat;
    int want;
    lat  = 0;
    want = last ? 0 : (4 >> d);
    chk_bit({tag, "/in_ready_idle"}, obs_in_ready[d], 1'b1);
    in_state_s     = st;
    in_last_s      = last;
    in_valid_v[d]  = 1'b1;
    out_ready_v[d] = 1'b0;
    tick();
    in_valid_v[d] = 1'b0;
    in_state_s    = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_last_s     = 1'($urandom_range(0, 1));
    while (!obs_out_valid[d] && lat < 20) begin
      tick();
      lat++;
    end
    chk_int({tag, "/latency"}, lat, want);
    chk_state({tag, "/out_state"}, obs_out_state[d], exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk_bit({tag, "/hold_valid"}, obs_out_valid[d], 1'b1);
      chk_bit({tag, "/hold_in_ready"}, obs_in_ready[d], 1'b0);
      chk_state({tag, "/hold_state"}, obs_out_state[d], exp);
    end
    out_ready_v[d] = 1'b1;
    tick();
    out_ready_v[d] = 1'b0;
    chk_bit({tag, "/valid_drop"}, obs_out_valid[d], 1'b0);
    chk_bit({tag, "/in_ready_back"}, obs_in_ready[d], 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] st;
    logic [127:0] blk [3];
    logic         last;
    logic         seen;
    int           acc, got, extra, cyc;
    int           acc_cyc [3];
    int           out_cyc [3];

    rst        = 1'b1;
    in_state_s = '0;
    in_last_s  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_v[d]  = 1'b0;
      out_ready_v[d] = 1'b0;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      chk_bit("rst/in_ready", obs_in_ready[d], 1'b0);
      chk_bit("rst/out_valid", obs_out_valid[d], 1'b0);
      chk_state("rst/out_state", obs_out_state[d], '0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk_bit("rst_release/in_ready", obs_in_ready[d], 1'b1);

    run_block(0, FIPS_IN, 1'b0, FIPS_OUT, 0, "fips_c1");
    run_block(0, V2_IN, 1'b0, V2_OUT, 10, "hold_c1");
    run_block(0, BYP_IN, 1'b1, BYP_IN, 0, "bypass_c1");
    run_block(1, FIPS_IN, 1'b0, FIPS_OUT, 0, "fips_c2");
    run_block(2, FIPS_IN, 1'b0, FIPS_OUT, 0, "fips_c4");
    run_block(2, BYP_IN, 1'b1, BYP_IN, 3, "bypass_c4");

    // Reset lands two edges after the accept, while the block is still BUSY.
    in_state_s    = FIPS_IN;
    in_last_s     = 1'b0;
    in_valid_v[0] = 1'b1;
    tick();
    in_valid_v[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk_bit("midrst/in_ready_in_rst", obs_in_ready[0], 1'b0);
    rst = 1'b0;
    #1;
    chk_bit("midrst/in_ready", obs_in_ready[0], 1'b1);
    chk_bit("midrst/out_valid", obs_out_valid[0], 1'b0);
    chk_state("midrst/out_state", obs_out_state[0], '0);
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (obs_out_valid[0]) seen = 1'b1;
    end
    chk_bit("midrst/no_output", seen, 1'b0);
    run_block(0, V2_IN, 1'b0, V2_OUT, 0, "post_rst");

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 4; n++) begin
        st   = {$urandom(), $urandom(), $urandom(), $urandom()};
        last = ($urandom_range(0, 3) == 0);
        run_block(d, st, last, last ? st : ref_mix(st), int'($urandom_range(0, 2)), "random");
      end
    end

    // Three blocks streamed with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      blk[i]     = {$urandom(), $urandom(), $urandom(), $urandom()};
      acc_cyc[i] = 0;
      out_cyc[i] = 0;
    end
    acc            = 0;
    got            = 0;
    extra          = 0;
    cyc            = 0;
    out_ready_v[0] = 1'b1;
    in_last_s      = 1'b0;
    in_state_s     = blk[0];
    in_valid_v[0]  = 1'b1;
    while ((acc < 3 || got < 3) && cyc < 100) begin
      if (obs_out_valid[0]) begin
        if (got < 3) begin
          chk_state("b2b/out_state", obs_out_state[0], ref_mix(blk[got]));
          out_cyc[got] = cyc;
          got++;
        end else begin
          extra++;
        end
      end
      if (obs_in_ready[0] && in_valid_v[0] && acc < 3) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
      tick();
      cyc++;
      if (acc < 3) in_state_s = blk[acc];
      else         in_valid_v[0] = 1'b0;
    end
    repeat (8) begin
      if (obs_out_valid[0]) extra++;
      tick();
    end
    out_ready_v[0] = 1'b0;
    chk_int("b2b/accepts", acc, 3);
    chk_int("b2b/outputs", got, 3);
    chk_int("b2b/extra_outputs", extra, 0);
    chk_int("b2b/accept_gap1", acc_cyc[1] - acc_cyc[0], 6);
    chk_int("b2b/accept_gap2", acc_cyc[2] - acc_cyc[1], 6);
    chk_int("b2b/output_gap1", out_cyc[1] - out_cyc[0], 6);
    chk_int("b2b/output_gap2", out_cyc[2] - out_cyc[1], 6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
